// File: rtl/uart_line_buffer_window.sv
`default_nettype none
// ============================================================================
// Module   : uart_line_buffer_window
// Brief    : 4-line ring buffer fed from the UART RX fetcher, scanned as
//            3-row pixel columns for a downstream 3x3 window stage.
// Revision : 1.0 - initial release
// ============================================================================
module uart_line_buffer_window #(
    parameter int LINE_W  = 256,
    parameter int FRAME_H = 256
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         read_req,
    input  logic                         read_data_valid,
    input  logic [7:0]                   rx_data,
    input  logic                         out_ready,
    output logic [7:0]                   pix_top,
    output logic [7:0]                   pix_mid,
    output logic [7:0]                   pix_bot,
    output logic                         pix_valid,
    output logic [$clog2(LINE_W)-1:0]    pix_col,
    output logic [$clog2(FRAME_H+1)-1:0] pix_row,
    output logic                         interrupt,
    output logic                         frame_done,
    output logic                         overflow
);

    localparam int c_col_w = $clog2(LINE_W);
    localparam int c_row_w = $clog2(FRAME_H + 1);
    localparam logic [c_col_w-1:0] c_col_max  = '1;
    localparam logic [c_row_w-1:0] c_slots    = c_row_w'(4);
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(FRAME_H - 3);
    localparam logic [c_row_w-1:0] c_irq_row  = c_row_w'(FRAME_H - 5);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_RELEASE = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic                r_strobe;
    logic [c_col_w-1:0]  r_wr_col;
    logic [1:0]          r_wr_slot;
    logic [c_row_w-1:0]  r_lines_written;
    logic [c_row_w-1:0]  r_row_released;
    logic [c_row_w-1:0]  r_row;
    logic                r_overflow;
    logic [7:0]          r_mem [0:4*LINE_W-1];

    logic [c_col_w-1:0]  r_rd_col;
    logic                r_rd_busy;
    logic                r_q_vld;
    logic [c_col_w-1:0]  r_q_col;
    logic [7:0]          r_q_top, r_q_mid, r_q_bot;

    logic                w_flush, w_release, w_start;
    logic [c_col_w-1:0]  w_wr_col_base;
    logic [1:0]          w_wr_slot_base;
    logic [c_row_w-1:0]  w_lines_base, w_lines_nxt, w_held;
    logic                w_drop, w_wr_en, w_wrap;
    logic                w_adv, w_rd_en, w_accept, w_last;
    logic [1:0]          w_slot_top, w_slot_mid, w_slot_bot;

    // During flush the write side sees an already-cleared frame, so a byte
    // landing in that cycle becomes column 0 of the next frame.
    assign w_flush        = (r_state == S_FLUSH);
    assign w_release      = (r_state == S_RELEASE);
    assign w_wr_col_base  = w_flush ? '0   : r_wr_col;
    assign w_wr_slot_base = w_flush ? 2'd0 : r_wr_slot;
    assign w_lines_base   = w_flush ? '0   : r_lines_written;
    assign w_held         = r_lines_written - r_row_released;
    assign w_drop         = r_strobe && !w_flush && !w_release
                            && (w_held == c_slots) && (r_wr_col == '0);
    assign w_wr_en        = r_strobe && !w_drop;
    assign w_wrap         = w_wr_en && (w_wr_col_base == c_col_max);
    assign w_lines_nxt    = w_lines_base + {{(c_row_w-1){1'b0}}, w_wrap};

    // Whole read pipeline freezes while a presented column is not taken.
    assign w_adv      = !pix_valid || out_ready;
    assign w_rd_en    = (r_state == S_SCAN) && r_rd_busy && w_adv;
    assign w_accept   = pix_valid && out_ready;
    assign w_last     = w_accept && (pix_col == c_col_max);
    assign w_slot_top = r_row[1:0];
    assign w_slot_mid = r_row[1:0] + 2'd1;
    assign w_slot_bot = r_row[1:0] + 2'd2;

    assign pix_row  = r_row;
    assign overflow = r_overflow;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        interrupt   = 1'b0;
        frame_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_lines_nxt >= r_row + c_row_w'(3)) begin
                    w_state_nxt = S_SCAN;
                    w_start     = 1'b1;
                end
            end
            S_SCAN: begin
                if (w_last) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (r_row == c_last_row) begin
                    frame_done  = 1'b1;
                    w_state_nxt = S_FLUSH;
                end else begin
                    interrupt   = (r_row <= c_irq_row);
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_strobe        <= 1'b0;
            r_wr_col        <= '0;
            r_wr_slot       <= 2'd0;
            r_lines_written <= '0;
            r_row_released  <= '0;
            r_row           <= '0;
            r_overflow      <= 1'b0;
            r_rd_col        <= '0;
            r_rd_busy       <= 1'b0;
            r_q_vld         <= 1'b0;
            r_q_col         <= '0;
            pix_valid       <= 1'b0;
            pix_col         <= '0;
            pix_top         <= 8'd0;
            pix_mid         <= 8'd0;
            pix_bot         <= 8'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_strobe        <= read_req && read_data_valid;
            r_wr_col        <= w_wr_en ? w_wr_col_base + c_col_w'(1) : w_wr_col_base;
            r_wr_slot       <= w_wrap ? w_wr_slot_base + 2'd1 : w_wr_slot_base;
            r_lines_written <= w_lines_nxt;
            if (w_drop) r_overflow <= 1'b1;

            if (w_flush) begin
                r_row_released <= '0;
                r_row          <= '0;
            end else if (w_release) begin
                r_row_released <= r_row_released + c_row_w'(1);
                if (r_row != c_last_row) r_row <= r_row + c_row_w'(1);
            end

            if (w_start) begin
                r_rd_col  <= '0;
                r_rd_busy <= 1'b1;
            end else if (w_rd_en) begin
                r_rd_col <= r_rd_col + c_col_w'(1);
                if (r_rd_col == c_col_max) r_rd_busy <= 1'b0;
            end

            if (w_adv) begin
                r_q_vld   <= w_rd_en;
                r_q_col   <= r_rd_col;
                pix_valid <= r_q_vld;
                if (r_q_vld) begin
                    pix_col <= r_q_col;
                    pix_top <= r_q_top;
                    pix_mid <= r_q_mid;
                    pix_bot <= r_q_bot;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[{w_wr_slot_base, w_wr_col_base}] <= rx_data;
        if (w_rd_en) begin
            r_q_top <= r_mem[{w_slot_top, r_rd_col}];
            r_q_mid <= r_mem[{w_slot_mid, r_rd_col}];
            r_q_bot <= r_mem[{w_slot_bot, r_rd_col}];
        end
    end

endmodule
`default_nettype wire
